uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an internal TX FIFO, configurable parity and stop-bit count, and exact per-bit timing. It sits between a bus-side producer (valid/ready byte stream) and the serial pin. Frames are sent back-to-back with no idle gap while the FIFO holds data. It supersedes the single-buffer transmitter, which holds off the producer for the whole frame.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   parity_t    : parity mode encoding (none / odd / even)
//   tx_state_t  : transmitter FSM states
//   frame_bits  : number of serial bits in one frame
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // start + data + optional parity + stop bits
  function automatic int unsigned frame_bits(input int unsigned data_width,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_width + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data (ignored while full)
//   pop      : read request (ignored while empty); dout shows the head entry
//   full, empty, count : occupancy status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal TX FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   data_tx    : word to enqueue, accepted when valid_tx && ready_tx
//   valid_tx   : producer offers data_tx
//   ready_tx   : FIFO not full
//   sig_tx     : registered serial line, idle high, LSB first
//   busy       : frame in progress or FIFO non-empty
//   fifo_count : current FIFO occupancy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       data_tx,
  input  logic                        valid_tx,
  output logic                        ready_tx,
  output logic                        sig_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int CW          = $clog2(PULSE_WIDTH);
  localparam int BW          = $clog2(frame_bits(DATA_WIDTH, PARITY, STOP_BITS));
  localparam logic [CW-1:0] BAUD_LOAD = CW'(PULSE_WIDTH - 1);
  localparam parity_t PAR_MODE = parity_t'(2'(PARITY));

  tx_state_t             state;
  logic [CW-1:0]         baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  bit_end;
  logic                  last_stop;
  logic                  pop;
  logic                  head_par;

  assign bit_end   = (baud_cnt == '0);
  assign last_stop = (state == STOP) && bit_end && (bit_cnt == BW'(STOP_BITS - 1));
  assign pop       = !fifo_empty && ((state == IDLE) || last_stop);
  assign head_par  = (PAR_MODE == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
  assign ready_tx  = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_tx),
    .din   (data_tx),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sig_tx   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        START: begin
          if (bit_end) begin
            state    <= DATA;
            sig_tx   <= shreg[0];
            shreg    <= shreg >> 1;
            bit_cnt  <= '0;
            baud_cnt <= BAUD_LOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              if (PAR_MODE != PAR_NONE) begin
                state  <= uart_pkg::PARITY;
                sig_tx <= par_bit;
              end else begin
                state  <= STOP;
                sig_tx <= 1'b1;
              end
            end else begin
              sig_tx  <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        uart_pkg::PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            sig_tx   <= 1'b1;
            bit_cnt  <= '0;
            baud_cnt <= BAUD_LOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              state <= IDLE;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              baud_cnt <= BAUD_LOAD;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          sig_tx <= 1'b1;
        end
      endcase

      // Frame load shared by IDLE and the end of STOP; overrides the
      // IDLE transition above so back-to-back frames have no gap.
      if (pop) begin
        state    <= START;
        sig_tx   <= 1'b0;
        shreg    <= fifo_dout;
        par_bit  <= head_par;
        bit_cnt  <= '0;
        baud_cnt <= BAUD_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three configurations driven with
// randomized byte streams; a monitor decodes sig_tx and checks every
// frame cycle-by-cycle against a reference model of the frame format.
module tb_uart_tx_fifo;

  localparam int PW = 10;
  localparam int NI = 3;

  typedef struct {
    logic [8:0] d;
    int         acc;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] vld;
  logic [7:0]    d0;
  logic [4:0]    d1;
  logic [7:0]    d2;
  wire  [NI-1:0] rdy;
  wire  [NI-1:0] sig;
  wire  [NI-1:0] bsy;
  wire  [2:0]    cnt0;
  wire  [2:0]    cnt1;
  wire  [4:0]    cnt2;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  item_t q0[$];
  item_t q1[$];
  item_t q2[$];

  bit         act     [NI];
  int         start_e [NI];
  int         prev_end[NI];
  int         werr    [NI];
  logic [8:0] rx      [NI];
  logic [8:0] cur     [NI];
  logic [15:0] expw   [NI];

  uart_tx_fifo #(.DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
                 .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) u0 (
    .clk(clk), .rst(rst), .data_tx(d0), .valid_tx(vld[0]), .ready_tx(rdy[0]),
    .sig_tx(sig[0]), .busy(bsy[0]), .fifo_count(cnt0));

  uart_tx_fifo #(.DATA_WIDTH(5), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
                 .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .data_tx(d1), .valid_tx(vld[1]), .ready_tx(rdy[1]),
    .sig_tx(sig[1]), .busy(bsy[1]), .fifo_count(cnt1));

  uart_tx_fifo #(.DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
                 .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .data_tx(d2), .valid_tx(vld[2]), .ready_tx(rdy[2]),
    .sig_tx(sig[2]), .busy(bsy[2]), .fifo_count(cnt2));

  // ---------------- configuration table ----------------
  function automatic int dw_of(int i);
    case (i) 0: return 8; 1: return 5; default: return 8; endcase
  endfunction
  function automatic int par_of(int i);
    case (i) 0: return 2; 1: return 1; default: return 0; endcase
  endfunction
  function automatic int sb_of(int i);
    case (i) 0: return 2; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int depth_of(int i);
    case (i) 0: return 4; 1: return 4; default: return 16; endcase
  endfunction
  function automatic int fb_of(int i);
    return 1 + dw_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i);
  endfunction

  function automatic int cnt_of(int i);
    case (i) 0: return int'(cnt0); 1: return int'(cnt1); default: return int'(cnt2); endcase
  endfunction
  function automatic logic [8:0] get_d(int i);
    case (i) 0: return {1'b0, d0}; 1: return {4'b0, d1}; default: return {1'b0, d2}; endcase
  endfunction
  task automatic set_d(input int i, input logic [8:0] v);
    case (i) 0: d0 = v[7:0]; 1: d1 = v[4:0]; default: d2 = v[7:0]; endcase
  endtask

  // ---------------- scoreboard queues ----------------
  function automatic int qsize(int i);
    case (i) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction
  function automatic void qpush(int i, item_t it);
    case (i) 0: q0.push_back(it); 1: q1.push_back(it); default: q2.push_back(it); endcase
  endfunction
  function automatic item_t qpop(int i);
    case (i) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
  endfunction

  function automatic void check(string name, int i, int got, int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d (cycle %0d)", name, i, got, exp_v, cyc);
    end
  endfunction

  // Reference frame: start 0, data LSB first, optional parity, stop ones.
  function automatic logic [15:0] build_frame(int i, logic [8:0] d);
    logic [15:0] f;
    int ones;
    int dw;
    f    = '1;
    ones = 0;
    dw   = dw_of(i);
    f[0] = 1'b0;
    for (int b = 0; b < dw; b++) begin
      f[b+1] = d[b];
      ones  += int'(d[b]);
    end
    if (par_of(i) == 1)      f[dw+1] = ((ones % 2) == 0);
    else if (par_of(i) == 2) f[dw+1] = ((ones % 2) == 1);
    return f;
  endfunction

  // ---------------- acceptance logging ----------------
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++)
        if (vld[i] && rdy[i]) qpush(i, '{d: get_d(i), acc: cyc});
    end
    cyc <= cyc + 1;
  end

  // ---------------- monitor ----------------
  function automatic void mon_step(int i);
    int    e;
    int    off;
    int    bitn;
    int    fb;
    int    expst;
    item_t it;
    e  = cyc - 1;
    fb = fb_of(i);
    if (!act[i] && sig[i] == 1'b0) begin
      if (qsize(i) == 0) begin
        check("unexpected_start", i, 1, 0);
      end else begin
        it    = qpop(i);
        expst = (it.acc + 1 > prev_end[i]) ? it.acc + 1 : prev_end[i];
        check("start_edge", i, e, expst);
        cur[i]     = it.d;
        expw[i]    = build_frame(i, it.d);
        act[i]     = 1'b1;
        start_e[i] = e;
        werr[i]    = 0;
        rx[i]      = '0;
      end
    end
    check("fifo_count", i, cnt_of(i), qsize(i));
    check("busy", i, int'(bsy[i]), int'(act[i] || qsize(i) > 0));
    check("ready_tx", i, int'(rdy[i]), int'(qsize(i) != depth_of(i)));
    if (act[i]) begin
      off  = e - start_e[i];
      bitn = off / PW;
      if (sig[i] !== expw[i][bitn]) werr[i]++;
      if ((off % PW) == PW / 2 && bitn >= 1 && bitn <= dw_of(i)) rx[i][bitn-1] = sig[i];
      if (off == fb * PW - 1) begin
        check("frame_wave", i, werr[i], 0);
        check("frame_data", i, int'(rx[i]), int'(cur[i]));
        act[i]      = 1'b0;
        prev_end[i] = start_e[i] + fb * PW;
      end
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        act[i]      = 1'b0;
        prev_end[i] = 0;
      end else begin
        mon_step(i);
      end
    end
  end

  // ---------------- stimulus ----------------
  // mode 0: directed opening bytes then random data with random gaps
  // mode 1: random data, back-to-back
  task automatic send_bytes(input int i, input int n, input int mode);
    int         g;
    int         budget;
    bit         acc;
    logic [8:0] v;
    for (int k = 0; k < n; k++) begin
      if (mode == 0 && k < 4)  g = (k == 0) ? 3 : 0;
      else if (mode == 0)      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 250)) : 0;
      else                     g = 0;
      repeat (g) @(negedge clk);
      if (mode == 0 && k == 0)     v = (i == 1) ? 9'h015 : 9'h0A5;
      else if (mode == 0 && k < 4) v = 9'(k);
      else                         v = 9'($urandom);
      set_d(i, v);
      vld[i] = 1'b1;
      budget = 0;
      do begin
        acc = rdy[i];
        @(negedge clk);
        budget++;
      end while (!acc && budget < 5000);
      if (!acc) check("accept_timeout", i, 0, 1);
      vld[i] = 1'b0;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((bsy != '0 || q0.size() != 0 || q1.size() != 0 || q2.size() != 0 ||
            act[0] || act[1] || act[2]) && b < 5000) begin
      @(negedge clk);
      b++;
    end
    check("drain_timeout", 0, int'(b < 5000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < NI; i++) begin
      check({tag, "_sig_tx"},     i, int'(sig[i]), 1);
      check({tag, "_ready_tx"},   i, int'(rdy[i]), 1);
      check({tag, "_busy"},       i, int'(bsy[i]), 0);
      check({tag, "_fifo_count"}, i, cnt_of(i), 0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, expected finish before 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    vld = '0;
    d0  = '0;
    d1  = '0;
    d2  = '0;
    for (int i = 0; i < NI; i++) begin
      act[i]      = 1'b0;
      prev_end[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    fork
      send_bytes(0, 30, 0);
      send_bytes(1, 30, 0);
      send_bytes(2, 40, 0);
    join
    drain();

    // Reset in the middle of a data phase with two words still queued.
    fork
      send_bytes(0, 3, 1);
      send_bytes(1, 3, 1);
      send_bytes(2, 3, 1);
    join
    repeat (30) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check("pre_reset_active", i, int'(act[i]), 1);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    #1;
    check_reset_values("midframe_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    fork
      send_bytes(0, 2, 1);
      send_bytes(1, 2, 1);
      send_bytes(2, 2, 1);
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
